sponge_ctrl: RTL and testbench



---
 rtl/sponge_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sponge_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sponge_ctrl.sv
// Keccak sponge control FSM: sequences absorb, permute and squeeze for one message at a time.
// Define SPONGE_XOF_STREAM_EN for unbounded XOF squeeze (out_len = 0) ended by squeeze_stop.
module sponge_ctrl #(
  parameter  int NUM_ROUNDS       = 24,
  parameter  int ROUNDS_PER_CYCLE = 1,
  parameter  int LEN_W            = 16,
  parameter  int MODE_W           = 2,
  localparam int CYCLES           = NUM_ROUNDS / ROUNDS_PER_CYCLE,
  localparam int RIDX_W           = $clog2(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [MODE_W-1:0] mode,
  input  logic [LEN_W-1:0]  out_len,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  input  logic              squeeze_stop,
  output logic              absorb_en,
  output logic              round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              state_clear,
  output logic [MODE_W-1:0] mode_q,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  if ((NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rounds_per_cycle
    $error("ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PERMUTE, S_WAIT, S_OUTPUT, S_SQUEEZE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_blocks_left;
  logic              r_last;
  logic [MODE_W-1:0] r_mode;
  logic              w_accept, w_out_hs, w_cnt_end, w_out_last;
  logic [RIDX_W-1:0] w_ridx;

  assign w_accept  = in_valid & ((r_state == S_IDLE) | (r_state == S_WAIT));
  assign w_out_hs  = out_ready & (r_state == S_OUTPUT);
  assign w_cnt_end = (r_cnt == CNT_W'(CYCLES - 1));
  assign w_ridx    = RIDX_W'(r_cnt * ROUNDS_PER_CYCLE);
  assign mode_q    = r_mode;

`ifdef SPONGE_XOF_STREAM_EN
  logic r_xof, r_stop;
  // An unbounded stream only ends once a stop request has been latched.
  assign w_out_last = r_xof ? r_stop : (r_blocks_left == LEN_W'(1));
`else
  logic w_unused;
  assign w_unused   = squeeze_stop;
  assign w_out_last = (r_blocks_left == LEN_W'(1));
`endif

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    absorb_en   = 1'b0;
    round_en    = 1'b0;
    round_idx   = '0;
    state_clear = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_INIT: begin
        state_clear = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        in_ready  = 1'b1;
        absorb_en = w_accept;
        if (w_accept) w_state_nxt = S_PERMUTE;
      end
      S_PERMUTE: begin
        round_en  = 1'b1;
        round_idx = w_ridx;
        busy      = 1'b1;
        if (w_cnt_end) w_state_nxt = r_last ? S_OUTPUT : S_WAIT;
      end
      S_WAIT: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        absorb_en = w_accept;
        if (w_accept) w_state_nxt = S_PERMUTE;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        out_last  = w_out_last;
        busy      = 1'b1;
        if (w_out_hs) begin
          if (w_out_last) begin
            done        = 1'b1;
            state_clear = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SQUEEZE;
          end
        end
      end
      S_SQUEEZE: begin
        round_en  = 1'b1;
        round_idx = w_ridx;
        busy      = 1'b1;
        if (w_cnt_end) w_state_nxt = S_OUTPUT;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_INIT;
      r_cnt         <= '0;
      r_blocks_left <= '0;
      r_last        <= 1'b0;
      r_mode        <= '0;
`ifdef SPONGE_XOF_STREAM_EN
      r_xof         <= 1'b0;
      r_stop        <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_PERMUTE) || (r_state == S_SQUEEZE))
        r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_last <= in_last;
        if (r_state == S_IDLE) begin
          r_mode        <= mode;
          r_blocks_left <= (out_len == '0) ? LEN_W'(1) : out_len;
          r_cnt         <= '0;
`ifdef SPONGE_XOF_STREAM_EN
          r_xof         <= (out_len == '0);
          r_stop        <= 1'b0;
`endif
        end
      end
      // An unbounded stream holds blocks_left at 1, so this guard also freezes it there.
      if (w_out_hs && !w_out_last && (r_blocks_left > LEN_W'(1)))
        r_blocks_left <= r_blocks_left - 1'b1;
`ifdef SPONGE_XOF_STREAM_EN
      if (r_xof && squeeze_stop && ((r_state == S_SQUEEZE) || (r_state == S_OUTPUT)))
        r_stop <= 1'b1;
      if (w_out_hs && w_out_last)
        r_stop <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sponge_ctrl.sv
// Self-checking bench for sponge_ctrl: two instances (1 and 4 rounds per cycle) compared
// every cycle against an event-timeline model derived from the handshake latency rules.
module tb_sponge_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_last, a_out_ready;
  logic        a_stop, a_absorb, a_round_en, a_clear, a_busy, a_done;
  logic [4:0]  a_ridx;
  logic [1:0]  a_mode, a_mode_q;
  logic [15:0] a_len;
  logic        b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_last, b_out_ready;
  logic        b_stop, b_absorb, b_round_en, b_clear, b_busy, b_done;
  logic [4:0]  b_ridx;
  logic [1:0]  b_mode, b_mode_q;
  logic [15:0] b_len;

  sponge_ctrl u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .mode(a_mode), .out_len(a_len), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(a_out_ready), .squeeze_stop(a_stop), .absorb_en(a_absorb), .round_en(a_round_en),
    .round_idx(a_ridx), .state_clear(a_clear), .mode_q(a_mode_q), .busy(a_busy), .done(a_done)
  );

  sponge_ctrl #(.ROUNDS_PER_CYCLE(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .mode(b_mode), .out_len(b_len), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(b_out_ready), .squeeze_stop(b_stop), .absorb_en(b_absorb), .round_en(b_round_en),
    .round_idx(b_ridx), .state_clear(b_clear), .mode_q(b_mode_q), .busy(b_busy), .done(b_done)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Expected message timeline: presentation/accept cycles per block, window/handshake per output.
  int p_t[8], acc_t[8], o_t[64], hs_t[64];
  int n_blk, m_blk, cyc_n, rpc, rdy_kind;
  bit rdy_rand[4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Bit order: in_ready absorb_en round_en round_idx[4:0] out_valid out_last done state_clear busy
  function automatic logic [12:0] obs_vec(input int which);
    if (which == 0)
      return {a_in_ready, a_absorb, a_round_en, a_ridx, a_out_valid, a_out_last, a_done, a_clear, a_busy};
    return {b_in_ready, b_absorb, b_round_en, b_ridx, b_out_valid, b_out_last, b_done, b_clear, b_busy};
  endfunction

  function automatic logic [1:0] obs_mode(input int which);
    return (which == 0) ? a_mode_q : b_mode_q;
  endfunction

  function automatic bit rdy_at(input int c);
    case (rdy_kind)
      0:       return 1'b1;
      1:       return (c >= o_t[0]) && (((c - o_t[0]) % 2) == 0);
      2:       return rdy_rand[c % 4096];
      default: return c >= o_t[0] + 50;
    endcase
  endfunction

  function automatic logic [12:0] exp_vec(input int c);
    bit ir, ab, re, ov, ol, dn, bz;
    int ri;
    ir = (c <= acc_t[0]) || (c > hs_t[m_blk-1]);
    ab = 1'b0; re = 1'b0; ov = 1'b0; ol = 1'b0; ri = 0;
    for (int k = 0; k < n_blk; k++) begin
      if (c == acc_t[k]) ab = 1'b1;
      if (k > 0 && c >= acc_t[k-1] + cyc_n + 1 && c <= acc_t[k]) ir = 1'b1;
      if (c > acc_t[k] && c <= acc_t[k] + cyc_n) begin re = 1'b1; ri = (c - acc_t[k] - 1) * rpc; end
    end
    for (int j = 0; j < m_blk; j++) begin
      if (c >= o_t[j] && c <= hs_t[j]) begin ov = 1'b1; ol = (j == m_blk - 1); end
      if (j < m_blk - 1 && c > hs_t[j] && c <= hs_t[j] + cyc_n) begin re = 1'b1; ri = (c - hs_t[j] - 1) * rpc; end
    end
    dn = (c == hs_t[m_blk-1]);
    bz = (c > acc_t[0]) && (c <= hs_t[m_blk-1]);
    return {ir, ab, re, 5'(ri), ov, ol, dn, dn, bz};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int which, input bit v, input bit l, input logic [1:0] md,
                       input logic [15:0] ln, input bit rd, input bit st);
    if (which == 0) begin
      a_in_valid = v; a_in_last = l; a_mode = md; a_len = ln; a_out_ready = rd; a_stop = st;
    end else begin
      b_in_valid = v; b_in_last = l; b_mode = md; b_len = ln; b_out_ready = rd; b_stop = st;
    end
  endtask

  task automatic idle_cycles(input int which, input int nc, input string tag);
    for (int i = 0; i < nc; i++) begin
      drive(which, 1'b0, 1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      check({tag, "/idle"}, 32'(obs_vec(which)), 32'h1000);
      tick();
    end
  endtask

  // One message of n blocks; stop_idx >= 0 selects an unbounded stream stopped after that handshake.
  task automatic run_msg(input int which, input int n, input int olen, input logic [1:0] md,
                         input int kind, input bit gaps, input int stop_idx, input string tag);
    bit v, l, st;
    logic [12:0] ev;
    cyc_n    = (which == 0) ? 24 : 6;
    rpc      = (which == 0) ? 1 : 4;
    rdy_kind = kind;
    n_blk    = n;
    m_blk    = (stop_idx >= 0) ? stop_idx + 2 : ((olen == 0) ? 1 : olen);
    p_t[0]   = cyc + (gaps ? int'($urandom_range(0, 2)) : 0);
    acc_t[0] = p_t[0];
    for (int k = 1; k < n; k++) begin
      p_t[k]   = acc_t[k-1] + 1 + (gaps ? int'($urandom_range(0, cyc_n + 3)) : 0);
      acc_t[k] = (p_t[k] > acc_t[k-1] + cyc_n + 1) ? p_t[k] : acc_t[k-1] + cyc_n + 1;
    end
    o_t[0] = acc_t[n-1] + cyc_n + 1;
    for (int j = 0; j < m_blk; j++) begin
      hs_t[j] = o_t[j];
      while (!rdy_at(hs_t[j]) && hs_t[j] < o_t[j] + 200) hs_t[j]++;
      if (j < m_blk - 1) o_t[j+1] = hs_t[j] + cyc_n + 1;
    end
    while (cyc <= hs_t[m_blk-1]) begin
      v = 1'b0;
      l = 1'($urandom);
      for (int k = 0; k < n; k++)
        if (cyc >= p_t[k] && cyc <= acc_t[k]) begin v = 1'b1; l = (k == n - 1); end
      st = (stop_idx >= 0) ? (cyc == hs_t[stop_idx] + 2) : 1'($urandom);
      drive(which, v, l, (cyc == acc_t[0]) ? md : 2'($urandom),
            (cyc == acc_t[0]) ? 16'(olen) : 16'($urandom), rdy_at(cyc), st);
      @(negedge clk);
      ev = exp_vec(cyc);
      check({tag, "/vec"}, 32'(obs_vec(which)), 32'(ev));
      if (ev[0]) check({tag, "/mode_q"}, 32'(obs_mode(which)), 32'(md));
      tick();
    end
    drive(which, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int which, n, olen;
    for (int i = 0; i < 4096; i++) rdy_rand[i] = 1'($urandom);
    drive(0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);

    // Power-on reset, one INIT cycle, then IDLE.
    @(negedge clk);
    check("reset_a", 32'(obs_vec(0)), 32'h0002);
    check("reset_b", 32'(obs_vec(1)), 32'h0002);
    check("reset_mode_q", 32'(a_mode_q), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_a", 32'(obs_vec(0)), 32'h0002);
    check("init_b", 32'(obs_vec(1)), 32'h0002);
    tick();
    idle_cycles(0, 3, "boot");

    run_msg(0, 1, 1, 2'd1, 0, 1'b0, -1, "single_block");
    idle_cycles(0, 1, "gap1");
    run_msg(1, 3, 1, 2'd2, 0, 1'b0, -1, "rpc4_held_valid");
    run_msg(0, 1, 3, 2'd3, 1, 1'b0, -1, "len3_toggle_ready");
`ifdef SPONGE_XOF_STREAM_EN
    run_msg(0, 1, 0, 2'd0, 0, 1'b0, 4, "xof_stop");
`else
    run_msg(0, 1, 0, 2'd0, 0, 1'b0, -1, "len0_as_1");
`endif
    run_msg(0, 2, 2, 2'd1, 3, 1'b1, -1, "stall_50");

    // Reset mid-PERMUTE with cnt = 12, then one INIT cycle and a normal message.
    drive(0, 1'b1, 1'b1, 2'd2, 16'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_mid/accept", 32'(obs_vec(0)), 32'h1800);
    tick();
    drive(0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    repeat (12) tick();
    check("rst_mid/cnt12", 32'(obs_vec(0)), 32'h0581);
    rst = 1'b1;
    #1;
    check("rst_mid/async", 32'(obs_vec(0)), 32'h0002);
    check("rst_mid/mode_q", 32'(a_mode_q), 32'h0);
    @(negedge clk);
    check("rst_mid/held", 32'(obs_vec(0)), 32'h0002);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/init", 32'(obs_vec(0)), 32'h0002);
    tick();
    run_msg(0, 1, 2, 2'd3, 0, 1'b1, -1, "after_reset");

    // Randomized messages, often back-to-back so a new accept follows done directly.
    for (int i = 0; i < 18; i++) begin
      which = (i % 3 == 2) ? 1 : 0;
      n     = int'($urandom_range(1, 3));
`ifdef SPONGE_XOF_STREAM_EN
      olen  = int'($urandom_range(1, 3));
`else
      olen  = int'($urandom_range(0, 3));
`endif
      run_msg(which, n, olen, 2'($urandom), int'($urandom_range(0, 2)), 1'b1, -1, "random");
      if ($urandom_range(0, 1) == 1) idle_cycles(which, int'($urandom_range(1, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
